// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared types and helpers for the sequential digit comparator.
//  Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Controller states: waiting for a request, or scanning digits.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Running comparison result carried down the digit cascade.
    typedef struct packed {
        logic eq;
        logic gt;
    } cmp_res_t;

    // Number of digit slices needed to cover an operand.
    function automatic int nslice(input int width, input int digit);
        return width / digit;
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/cmp_digit_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_digit_slice
//  Purpose  : One cascaded unsigned digit comparator (eq/gt chain element).
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_digit_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             eq,
    output logic             gt
);

    // A decision made by a more-significant digit passes through untouched;
    // otherwise this digit decides.
    always_comb begin
        eq = 1'b0;
        gt = gt_in;
        if (eq_in) begin
            eq = (x == y);
            gt = (x > y);
        end
    end

endmodule : cmp_digit_slice
`default_nettype wire

// File: rtl/seq_digit_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_digit_comparator
//  Purpose  : Sequential MSB-first magnitude comparator, DIGIT bits per clock,
//             with optional signed mode, early exit and cascade inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_digit_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int c_nslice = nslice(WIDTH, DIGIT);
    localparam int c_kw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_width_check
            $error("seq_digit_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [c_kw-1:0]   r_k;
    cmp_res_t          r_run;
    cmp_res_t          w_slice;
    logic              w_exit;
    logic              w_accept;
    logic [WIDTH-1:0]  w_msb_flip;
    logic              r_done;
    logic              r_eq;
    logic              r_gt;
    logic              r_lt;

    // Biasing the sign bit turns a two's-complement compare into an unsigned
    // one; only the top digit is affected, so it is applied once at capture.
    assign w_msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
    assign w_accept   = (r_state == IDLE) && start;

    // Operands are shifted left each RUN cycle so the digit under test is
    // always the top DIGIT bits of the operand registers.
    cmp_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x     (r_a[WIDTH-1 -: DIGIT]),
        .y     (r_b[WIDTH-1 -: DIGIT]),
        .eq_in (r_run.eq),
        .gt_in (r_run.gt),
        .eq    (w_slice.eq),
        .gt    (w_slice.gt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; exit after the last digit or on the first decision.
    always_comb begin
        w_state_next = r_state;
        w_exit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if ((r_k == '0) || ((EARLY_EXIT != 0) && !w_slice.eq)) begin
                    w_state_next = IDLE;
                    w_exit       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, digit scan and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_k    <= '0;
            r_run  <= '0;
            r_done <= 1'b0;
            r_eq   <= 1'b0;
            r_gt   <= 1'b0;
            r_lt   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a      <= a ^ w_msb_flip;
                r_b      <= b ^ w_msb_flip;
                r_k      <= c_kw'(c_nslice - 1);
                r_run.eq <= eq_in;
                r_run.gt <= gt_in;
            end else if (r_state == RUN) begin
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_k   <= r_k - c_kw'(1);
                r_run <= w_slice;
                if (w_exit) begin
                    r_eq   <= w_slice.eq;
                    r_gt   <= w_slice.gt;
                    r_lt   <= ~w_slice.eq & ~w_slice.gt;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule : seq_digit_comparator
`default_nettype wire

// File: tb/tb_seq_digit_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_digit_comparator
//  Purpose  : Scoreboard bench for seq_digit_comparator; drives an early-exit
//             and a full-scan instance with identical stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_digit_comparator;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int NS = W / D;

    typedef struct {
        logic [2:0] res;     // {eq, gt, lt}
        int         m;       // digits evaluated
        int         launch;  // cycle count when start was raised
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         signed_mode = 1'b0;
    logic         eq_in = 1'b1;
    logic         gt_in = 1'b0;

    logic busy_ee, done_ee, eq_ee, gt_ee, lt_ee;
    logic busy_fe, done_fe, eq_fe, gt_fe, lt_fe;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   busy_n_ee = 0;
    int   busy_n_fe = 0;
    exp_t q_ee[$];
    exp_t q_fe[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_digit_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .eq_in(eq_in), .gt_in(gt_in),
        .busy(busy_ee), .done(done_ee), .eq(eq_ee), .gt(gt_ee), .lt(lt_ee)
    );

    seq_digit_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) dut_fe (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .eq_in(eq_in), .gt_in(gt_in),
        .busy(busy_fe), .done(done_fe), .eq(eq_fe), .gt(gt_fe), .lt(lt_fe)
    );

    // Reference: plain integer comparison; latency from the most significant
    // differing digit.
    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic sm, input logic eqi, input logic gti,
                                   input bit early, input int launch);
        exp_t e;
        logic e_eq, e_gt;
        logic [W-1:0] diff;
        int top;
        e.launch = launch;
        if (!eqi) begin
            e_eq = 1'b0;
            e_gt = gti;
            e.m  = early ? 1 : NS;
        end else begin
            e_eq = (va == vb);
            if (sm) e_gt = ($signed(va) > $signed(vb));
            else    e_gt = (va > vb);
            diff = va ^ vb;
            top  = -1;
            for (int i = 0; i < W; i++) if (diff[i]) top = i;
            e.m = (!early || top < 0) ? NS : NS - (top / D);
        end
        e.res = {e_eq, e_gt, ~e_eq & ~e_gt};
        return e;
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_op(input string tag, input logic [2:0] act, input int busy_n, input exp_t e);
        n_cmp++;
        if (act !== e.res) begin
            n_fail++;
            $display("FAIL %s result {eq,gt,lt}: got %b, expected %b", tag, act, e.res);
        end
        check_int({tag, " latency"}, cyc - e.launch, e.m + 1);
        check_int({tag, " busy cycles"}, busy_n, e.m);
    endtask

    // Early-exit instance monitor.
    always @(negedge clk) begin
        if (rst) begin
            busy_n_ee = 0;
        end else begin
            if (busy_ee) busy_n_ee++;
            if (done_ee) begin
                if (q_ee.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL ee unexpected done at cycle %0d", cyc);
                end else begin
                    check_op("ee", {eq_ee, gt_ee, lt_ee}, busy_n_ee, q_ee.pop_front());
                end
                busy_n_ee = 0;
            end
        end
    end

    // Full-scan instance monitor.
    always @(negedge clk) begin
        if (rst) begin
            busy_n_fe = 0;
        end else begin
            if (busy_fe) busy_n_fe++;
            if (done_fe) begin
                if (q_fe.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL fe unexpected done at cycle %0d", cyc);
                end else begin
                    check_op("fe", {eq_fe, gt_fe, lt_fe}, busy_n_fe, q_fe.pop_front());
                end
                busy_n_fe = 0;
            end
        end
    end

    // Called just after a rising edge: present a request for one cycle, then
    // scramble the inputs to show they are not re-sampled.
    task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic sm, input logic eqi, input logic gti);
        a = va; b = vb; signed_mode = sm; eq_in = eqi; gt_in = gti; start = 1'b1;
        q_ee.push_back(model(va, vb, sm, eqi, gti, 1'b1, cyc));
        q_fe.push_back(model(va, vb, sm, eqi, gti, 1'b0, cyc));
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        signed_mode = 1'($urandom); eq_in = 1'($urandom); gt_in = 1'($urandom);
    endtask

    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic sm, input logic eqi, input logic gti);
        @(posedge clk); #1;
        drive_start(va, vb, sm, eqi, gti);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (q_ee.size() == 0 && q_fe.size() == 0) break;
            @(posedge clk);
        end
        if (q_ee.size() != 0 || q_fe.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout waiting for done: ee pending %0d, fe pending %0d",
                     q_ee.size(), q_fe.size());
            q_ee.delete(); q_fe.delete();
        end
    endtask

    task automatic check_cleared(input string name);
        @(negedge clk);
        check_int({name, " ee outputs"}, {busy_ee, done_ee, eq_ee, gt_ee, lt_ee}, 0);
        check_int({name, " fe outputs"}, {busy_fe, done_fe, eq_fe, gt_fe, lt_fe}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_cleared("reset");

        // Equal operands: full scan on both instances.
        issue(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);             wait_idle();
        // Top digit decides, unsigned then signed.
        issue(8'hC0, 8'h40, 1'b0, 1'b1, 1'b0);             wait_idle();
        issue(8'hC0, 8'h40, 1'b1, 1'b1, 1'b0);             wait_idle();
        // Difference only in the last digit.
        issue(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);             wait_idle();
        // Cascade decision dominates.
        issue(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);             wait_idle();
        issue(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);             wait_idle();

        // Start while busy is ignored.
        issue(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        a = 8'h00; b = 8'hFF; eq_in = 1'b0; gt_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Reset in RUN cycle 2 aborts with no done pulse.
        issue(8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_ee.delete(); q_fe.delete();
        check_cleared("abort");
        repeat (6) @(posedge clk);

        // Back-to-back: new request raised in the done cycle.
        issue(8'h77, 8'h77, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done_fe) break;
        end
        drive_start(8'h12, 8'h13, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Randomized operations, biased towards shared upper digits.
        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
            issue(ra, rb, 1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom));
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seq_digit_comparator
`default_nettype wire
